// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the multicycle MIPS-subset core control path
package cpu_types_pkg;

  localparam int OP_W   = 6;
  localparam int FUNC_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [FUNC_W-1:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RD_RD  = 2'd0,
    RD_RT  = 2'd1,
    RD_R31 = 2'd2
  } regdst_t;

  typedef enum logic [1:0] {
    SRC_RT    = 2'd0,
    SRC_IMM_S = 2'd1,
    SRC_IMM_Z = 2'd2,
    SRC_SHAMT = 2'd3
  } alusrc_t;

  typedef enum logic [1:0] {
    WS_ALU = 2'd0,
    WS_MEM = 2'd1,
    WS_PC4 = 2'd2,
    WS_LUI = 2'd3
  } wsel_t;

  typedef enum logic [1:0] {
    PC_PC4    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pcsrc_t;

  typedef enum logic [3:0] {
    CL_RALU    = 4'd0,
    CL_SHIFT   = 4'd1,
    CL_IALU_S  = 4'd2,
    CL_IALU_Z  = 4'd3,
    CL_LUI     = 4'd4,
    CL_LOAD    = 4'd5,
    CL_STORE   = 4'd6,
    CL_BRANCH  = 4'd7,
    CL_JUMP    = 4'd8,
    CL_JAL     = 4'd9,
    CL_JR      = 4'd10,
    CL_HALT    = 4'd11,
    CL_ILLEGAL = 4'd12
  } instr_class_t;

  // ALU B operand for each class; held stable from EXEC through WB
  function automatic alusrc_t class_alusrc(instr_class_t c);
    case (c)
      CL_SHIFT:                     return SRC_SHAMT;
      CL_IALU_S, CL_LOAD, CL_STORE: return SRC_IMM_S;
      CL_IALU_Z:                    return SRC_IMM_Z;
      default:                      return SRC_RT;
    endcase
  endfunction

  // Destination register in WB: only R-type writes rd, everything else writes rt
  function automatic regdst_t wb_regdst(instr_class_t c);
    case (c)
      CL_RALU, CL_SHIFT: return RD_RD;
      default:           return RD_RT;
    endcase
  endfunction

  // Writeback data source in WB
  function automatic wsel_t wb_wsel(instr_class_t c);
    case (c)
      CL_LOAD: return WS_MEM;
      CL_LUI:  return WS_LUI;
      default: return WS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/status bundle between the FSM and the datapath
interface multicycle_control_if;
  import cpu_types_pkg::*;

  // status from decoder, ALU and memories
  logic [OP_W-1:0]   opcode;
  logic [FUNC_W-1:0] funct;
  logic              zero;
  logic              ihit;
  logic              dhit;

  // controls to the datapath
  logic              imemren;
  logic              irwen;
  logic              dmemren;
  logic              dmemwen;
  logic              regwen;
  regdst_t           regdst;
  alusrc_t           alusrc;
  aluop_t            aluop;
  wsel_t             wsel;
  pcsrc_t            pcsrc;
  logic              pcen;
  logic              halt;
  ctrl_state_t       state;

  modport master (
    input  opcode, funct, zero, ihit, dhit,
    output imemren, irwen, dmemren, dmemwen, regwen, regdst, alusrc,
           aluop, wsel, pcsrc, pcen, halt, state
  );

  modport slave (
    output opcode, funct, zero, ihit, dhit,
    input  imemren, irwen, dmemren, dmemwen, regwen, regdst, alusrc,
           aluop, wsel, pcsrc, pcen, halt, state
  );

endinterface

// File: rtl/ctrl_class_decode.sv
// rtl/ctrl_class_decode.sv - maps opcode/funct to an instruction class and ALU operation
module ctrl_class_decode
  import cpu_types_pkg::*;
(
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [FUNC_W-1:0] funct_i,
  output instr_class_t      iclass_o,
  output aluop_t            aluop_o,
  output logic              br_ne_o
);

  // Pure table lookup; anything not listed is ILLEGAL and executes as a NOP
  always_comb begin
    iclass_o = CL_ILLEGAL;
    aluop_o  = ALU_ADD;
    br_ne_o  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_SLL:          begin iclass_o = CL_SHIFT; aluop_o = ALU_SLL;  end
          FN_SRL:          begin iclass_o = CL_SHIFT; aluop_o = ALU_SRL;  end
          FN_JR:           begin iclass_o = CL_JR;                        end
          FN_ADD, FN_ADDU: begin iclass_o = CL_RALU;  aluop_o = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin iclass_o = CL_RALU;  aluop_o = ALU_SUB;  end
          FN_AND:          begin iclass_o = CL_RALU;  aluop_o = ALU_AND;  end
          FN_OR:           begin iclass_o = CL_RALU;  aluop_o = ALU_OR;   end
          FN_XOR:          begin iclass_o = CL_RALU;  aluop_o = ALU_XOR;  end
          FN_NOR:          begin iclass_o = CL_RALU;  aluop_o = ALU_NOR;  end
          FN_SLT:          begin iclass_o = CL_RALU;  aluop_o = ALU_SLT;  end
          FN_SLTU:         begin iclass_o = CL_RALU;  aluop_o = ALU_SLTU; end
          default:         iclass_o = CL_ILLEGAL;
        endcase
      end
      OP_J:              iclass_o = CL_JUMP;
      OP_JAL:            iclass_o = CL_JAL;
      OP_BEQ:            begin iclass_o = CL_BRANCH; aluop_o = ALU_SUB; end
      OP_BNE:            begin iclass_o = CL_BRANCH; aluop_o = ALU_SUB; br_ne_o = 1'b1; end
      OP_ADDI, OP_ADDIU: begin iclass_o = CL_IALU_S; aluop_o = ALU_ADD;  end
      OP_SLTI:           begin iclass_o = CL_IALU_S; aluop_o = ALU_SLT;  end
      OP_SLTIU:          begin iclass_o = CL_IALU_S; aluop_o = ALU_SLTU; end
      OP_ANDI:           begin iclass_o = CL_IALU_Z; aluop_o = ALU_AND;  end
      OP_ORI:            begin iclass_o = CL_IALU_Z; aluop_o = ALU_OR;   end
      OP_XORI:           begin iclass_o = CL_IALU_Z; aluop_o = ALU_XOR;  end
      OP_LUI:            iclass_o = CL_LUI;
      OP_LW:             begin iclass_o = CL_LOAD;  aluop_o = ALU_ADD; end
      OP_SW:             begin iclass_o = CL_STORE; aluop_o = ALU_ADD; end
      OP_HALT:           iclass_o = CL_HALT;
      default:           iclass_o = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control FSM
module multicycle_control
  import cpu_types_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  multicycle_control_if.master bus
);

  ctrl_state_t  state_q, state_d;
  instr_class_t iclass;
  aluop_t       class_aluop;
  logic         br_ne;
  logic         br_taken;

  ctrl_class_decode u_decode (
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .iclass_o (iclass),
    .aluop_o  (class_aluop),
    .br_ne_o  (br_ne)
  );

  // BEQ takes on equal operands, BNE on unequal
  assign br_taken  = br_ne ? ~bus.zero : bus.zero;
  assign bus.state = state_q;

  // State register; a reset anywhere abandons the in-flight instruction
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and controls; only ihit, dhit and zero qualify within a state
  always_comb begin
    state_d     = state_q;
    bus.imemren = 1'b0;
    bus.irwen   = 1'b0;
    bus.dmemren = 1'b0;
    bus.dmemwen = 1'b0;
    bus.regwen  = 1'b0;
    bus.regdst  = RD_RD;
    bus.alusrc  = SRC_RT;
    bus.aluop   = ALU_SLL;
    bus.wsel    = WS_ALU;
    bus.pcsrc   = PC_PC4;
    bus.pcen    = 1'b0;
    bus.halt    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        bus.imemren = 1'b1;
        if (bus.ihit) begin
          bus.irwen = 1'b1;
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = (iclass == CL_HALT) ? ST_HALTED : ST_EXEC;
      end

      ST_EXEC: begin
        bus.aluop  = class_aluop;
        bus.alusrc = class_alusrc(iclass);
        case (iclass)
          CL_RALU, CL_SHIFT, CL_IALU_S, CL_IALU_Z, CL_LUI: begin
            state_d = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            state_d = ST_MEM;
          end
          CL_BRANCH: begin
            bus.pcen  = 1'b1;
            bus.pcsrc = br_taken ? PC_BRANCH : PC_PC4;
            state_d   = ST_FETCH;
          end
          CL_JUMP: begin
            bus.pcen  = 1'b1;
            bus.pcsrc = PC_JUMP;
            state_d   = ST_FETCH;
          end
          CL_JAL: begin
            bus.pcen   = 1'b1;
            bus.pcsrc  = PC_JUMP;
            bus.regwen = 1'b1;
            bus.regdst = RD_R31;
            bus.wsel   = WS_PC4;
            state_d    = ST_FETCH;
          end
          CL_JR: begin
            bus.pcen  = 1'b1;
            bus.pcsrc = PC_RS;
            state_d   = ST_FETCH;
          end
          default: begin
            // unknown encodings retire as a NOP
            bus.pcen  = 1'b1;
            bus.pcsrc = PC_PC4;
            state_d   = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        // keep the address computation stable while the access is pending
        bus.aluop  = class_aluop;
        bus.alusrc = class_alusrc(iclass);
        if (iclass == CL_LOAD) begin
          bus.dmemren = 1'b1;
          if (bus.dhit) begin
            state_d = ST_WB;
          end
        end else if (iclass == CL_STORE) begin
          bus.dmemwen = 1'b1;
          if (bus.dhit) begin
            bus.pcen  = 1'b1;
            bus.pcsrc = PC_PC4;
            state_d   = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_WB: begin
        bus.aluop  = class_aluop;
        bus.alusrc = class_alusrc(iclass);
        bus.regwen = 1'b1;
        bus.regdst = wb_regdst(iclass);
        bus.wsel   = wb_wsel(iclass);
        bus.pcen   = 1'b1;
        bus.pcsrc  = PC_PC4;
        state_d    = ST_FETCH;
      end

      ST_HALTED: begin
        bus.halt = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized scoreboard bench for multicycle_control
module tb_multicycle_control;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  typedef struct {
    string name;
    int    cycles;
    int    pcsrc;
    int    nregwen;
    int    regdst;
    int    wsel;
    int    nrd;
    int    nwr;
    int    states;
    bit    chk_aluop;
    int    aluop;
    bit    chk_alusrc;
    int    alusrc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   fresh       = 1'b0;

  task automatic check(string nm, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int sbit(ctrl_state_t s);
    return 1 << int'(s);
  endfunction

  // ALU operation for R-type functs; -1 when the funct is not an ALU op
  function automatic int r_alu(logic [5:0] fn);
    case (fn)
      6'h00: return int'(ALU_SLL);
      6'h02: return int'(ALU_SRL);
      6'h20, 6'h21: return int'(ALU_ADD);
      6'h22, 6'h23: return int'(ALU_SUB);
      6'h24: return int'(ALU_AND);
      6'h25: return int'(ALU_OR);
      6'h26: return int'(ALU_XOR);
      6'h27: return int'(ALU_NOR);
      6'h2A: return int'(ALU_SLT);
      6'h2B: return int'(ALU_SLTU);
      default: return -1;
    endcase
  endfunction

  // ALU operation for immediate ALU opcodes; -1 otherwise
  function automatic int i_alu(logic [5:0] op);
    case (op)
      6'h08, 6'h09: return int'(ALU_ADD);
      6'h0A: return int'(ALU_SLT);
      6'h0B: return int'(ALU_SLTU);
      6'h0C: return int'(ALU_AND);
      6'h0D: return int'(ALU_OR);
      6'h0E: return int'(ALU_XOR);
      default: return -1;
    endcase
  endfunction

  // Expected retirement behaviour of one instruction, from the instruction rules
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn, bit z, int iw, int dw);
    exp_t e;
    int   fd;
    int   a;
    fd = iw + 2;
    e.name = $sformatf("op%02h_fn%02h_z%0d_iw%0d_dw%0d", op, fn, z, iw, dw);
    e.cycles = fd + 1; e.pcsrc = 0; e.nregwen = 0; e.regdst = 0; e.wsel = 0;
    e.nrd = 0; e.nwr = 0; e.chk_aluop = 0; e.aluop = 0; e.chk_alusrc = 0; e.alusrc = 0;
    e.states = sbit(ST_FETCH) | sbit(ST_DECODE) | sbit(ST_EXEC);
    if (op == 6'h00) begin
      a = r_alu(fn);
      if (fn == 6'h08) begin
        e.pcsrc = 3;
      end else if (a >= 0) begin
        e.cycles = fd + 2; e.states |= sbit(ST_WB); e.nregwen = 1;
        e.chk_aluop = 1; e.aluop = a;
        e.chk_alusrc = 1; e.alusrc = (fn == 6'h00 || fn == 6'h02) ? 3 : 0;
      end
    end else if (i_alu(op) >= 0) begin
      e.cycles = fd + 2; e.states |= sbit(ST_WB); e.nregwen = 1; e.regdst = 1;
      e.chk_aluop = 1; e.aluop = i_alu(op);
      e.chk_alusrc = 1; e.alusrc = (op >= 6'h0C) ? 2 : 1;
    end else begin
      case (op)
        6'h0F: begin
          e.cycles = fd + 2; e.states |= sbit(ST_WB); e.nregwen = 1; e.regdst = 1; e.wsel = 3;
        end
        6'h23: begin
          e.cycles = fd + 1 + (dw + 1) + 1; e.states |= sbit(ST_MEM) | sbit(ST_WB);
          e.nrd = dw + 1; e.nregwen = 1; e.regdst = 1; e.wsel = 1;
          e.chk_aluop = 1; e.aluop = int'(ALU_ADD); e.chk_alusrc = 1; e.alusrc = 1;
        end
        6'h2B: begin
          e.cycles = fd + 1 + (dw + 1); e.states |= sbit(ST_MEM); e.nwr = dw + 1;
          e.chk_aluop = 1; e.aluop = int'(ALU_ADD); e.chk_alusrc = 1; e.alusrc = 1;
        end
        6'h04, 6'h05: begin
          e.pcsrc = ((op == 6'h04) == z) ? 1 : 0;
          e.chk_aluop = 1; e.aluop = int'(ALU_SUB);
        end
        6'h02: e.pcsrc = 2;
        6'h03: begin
          e.pcsrc = 2; e.nregwen = 1; e.regdst = 2; e.wsel = 2;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Monitor: accumulate per-instruction observations, compare on each pcen
  int   m_cyc = 0, m_rw = 0, m_rd = 0, m_wr = 0, m_irw = 0, m_states = 0;
  int   m_regdst = 0, m_wsel = 0, m_aluop = 0, m_alusrc = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!nrst) begin
      m_cyc = 0; m_rw = 0; m_rd = 0; m_wr = 0; m_irw = 0; m_states = 0;
    end else begin
      m_cyc++;
      m_states |= 1 << int'(bus.state);
      if (bus.irwen) m_irw++;
      if (bus.regwen) begin
        m_rw++; m_regdst = int'(bus.regdst); m_wsel = int'(bus.wsel);
      end
      if (bus.dmemren) m_rd++;
      if (bus.dmemwen) m_wr++;
      if (bus.dmemren || bus.dmemwen)
        check("dmem_exclusive", int'(bus.dmemren & bus.dmemwen), 0);
      if (bus.state == ST_EXEC) begin
        m_aluop = int'(bus.aluop); m_alusrc = int'(bus.alusrc);
      end
      if (bus.pcen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pcen", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, " cycles"}, m_cyc, mon_e.cycles);
          check({mon_e.name, " pcsrc"}, int'(bus.pcsrc), mon_e.pcsrc);
          check({mon_e.name, " regwen_count"}, m_rw, mon_e.nregwen);
          if (mon_e.nregwen > 0) begin
            check({mon_e.name, " regdst"}, m_regdst, mon_e.regdst);
            check({mon_e.name, " wsel"}, m_wsel, mon_e.wsel);
          end
          check({mon_e.name, " dmemren_cycles"}, m_rd, mon_e.nrd);
          check({mon_e.name, " dmemwen_cycles"}, m_wr, mon_e.nwr);
          check({mon_e.name, " irwen_count"}, m_irw, 1);
          check({mon_e.name, " states"}, m_states, mon_e.states);
          if (mon_e.chk_aluop) check({mon_e.name, " aluop"}, m_aluop, mon_e.aluop);
          if (mon_e.chk_alusrc) check({mon_e.name, " alusrc"}, m_alusrc, mon_e.alusrc);
        end
        m_cyc = 0; m_rw = 0; m_rd = 0; m_wr = 0; m_irw = 0; m_states = 0;
      end
    end
  end

  // Issue one instruction acting as the memories; expectation queued first
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit z, int iw_in, int dw);
    int n;
    int iw;
    iw = (fresh && iw_in == 0) ? 1 : iw_in;
    fresh = 1'b0;
    exp_q.push_back(model(op, fn, z, iw, dw));
    bus.opcode = op; bus.funct = fn; bus.zero = z; bus.ihit = 1'b0; bus.dhit = 1'b0;
    repeat (iw) @(posedge clk) #1;
    bus.ihit = 1'b1;
    @(posedge clk) #1;
    bus.ihit = 1'b0;
    if (op == 6'h23 || op == 6'h2B) begin
      n = 0;
      while (!(bus.dmemren || bus.dmemwen) && n < 8) begin
        @(posedge clk) #1; n++;
      end
      if (n == 8) check("dmem_request_timeout", 1, 0);
      repeat (dw) @(posedge clk) #1;
      bus.dhit = 1'b1;
      @(posedge clk) #1;
      bus.dhit = 1'b0;
    end
    n = 0;
    while (!bus.imemren && n < 12) begin
      @(posedge clk) #1; n++;
    end
    if (n == 12) check("fetch_return_timeout", 1, 0);
  endtask

  task automatic apply_reset();
    bus.ihit = 1'b0; bus.dhit = 1'b0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    fresh = 1'b1;
  endtask

  logic [5:0] op_tab [20];
  logic [5:0] fn_tab [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int iw, dw, n;
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
               6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h11, 6'h3E};
    fn_tab = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
               6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F, 6'h18};
    nrst = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.ihit = 1'b0; bus.dhit = 1'b0;

    // in reset
    @(posedge clk) #1;
    check("in_reset state", int'(bus.state), int'(ST_FETCH));
    check("in_reset halt", int'(bus.halt), 0);
    check("in_reset pcen", int'(bus.pcen), 0);
    check("in_reset regwen", int'(bus.regwen), 0);
    apply_reset();
    // first cycle after reset
    #1;
    check("post_reset imemren", int'(bus.imemren), 1);
    check("post_reset irwen", int'(bus.irwen), 0);
    check("post_reset pcen", int'(bus.pcen), 0);
    check("post_reset regwen", int'(bus.regwen), 0);
    check("post_reset dmem", int'(bus.dmemren | bus.dmemwen), 0);
    check("post_reset halt", int'(bus.halt), 0);

    // directed instructions
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // J
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // ADD
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // LW with 3 dhit wait cycles
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // BEQ not taken
    run_instr(6'h05, 6'h00, 1'b0, 0, 0);   // BNE taken
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // JAL
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // JR
    run_instr(6'h0F, 6'h00, 1'b0, 2, 0);   // LUI
    run_instr(6'h0D, 6'h00, 1'b0, 0, 0);   // ORI
    run_instr(6'h00, 6'h00, 1'b0, 0, 0);   // SLL
    run_instr(6'h2B, 6'h00, 1'b0, 1, 2);   // SW
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0);   // SW zero wait
    run_instr(6'h3E, 6'h00, 1'b0, 0, 0);   // unknown opcode

    // HALT: absorbing despite ihit activity, cleared only by reset
    bus.opcode = 6'h3F; bus.funct = 6'h00;
    bus.ihit = 1'b1;
    @(posedge clk) #1;
    bus.ihit = 1'b0;
    @(posedge clk) #1;
    for (int k = 0; k < 24; k++) begin
      check("halted halt", int'(bus.halt), 1);
      check("halted state", int'(bus.state), int'(ST_HALTED));
      check("halted imemren", int'(bus.imemren), 0);
      bus.ihit = ($urandom_range(0, 1) == 1);
      @(posedge clk) #1;
    end
    bus.ihit = 1'b0;
    nrst = 1'b0;
    #1;
    check("halt_reset halt", int'(bus.halt), 0);
    check("halt_reset state", int'(bus.state), int'(ST_FETCH));
    @(posedge clk) #1;
    nrst = 1'b1; fresh = 1'b1;
    check("halt_restart imemren", int'(bus.imemren), 1);

    // SW aborted by reset in the middle of MEM; no pcen may appear
    bus.opcode = 6'h2B; bus.funct = 6'h00;
    @(posedge clk) #1;
    bus.ihit = 1'b1;
    @(posedge clk) #1;
    bus.ihit = 1'b0;
    n = 0;
    while (!bus.dmemwen && n < 8) begin
      @(posedge clk) #1; n++;
    end
    check("abort dmemwen_seen", int'(bus.dmemwen), 1);
    @(posedge clk) #2;
    nrst = 1'b0;
    #1;
    check("abort dmemwen", int'(bus.dmemwen), 0);
    check("abort pcen", int'(bus.pcen), 0);
    check("abort regwen", int'(bus.regwen), 0);
    check("abort state", int'(bus.state), int'(ST_FETCH));
    @(posedge clk) #1;
    nrst = 1'b1; fresh = 1'b1;
    #1;
    check("abort_restart imemren", int'(bus.imemren), 1);

    // randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      op = op_tab[$urandom_range(0, 19)];
      fn = fn_tab[$urandom_range(0, 15)];
      iw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      dw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_instr(op, fn, ($urandom_range(0, 1) == 1), iw, dw);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
